// File: rtl/scene_renderer.sv
// scene_renderer: 640x480 VGA timing, per-frame object shadow registers, 2-stage hit/colour pipeline.
// Latency: rgb, hsync, vsync and video_on lag the raster counters (xaddr/yaddr) by exactly 2 pix_ce ticks.
// Backpressure: none; pix_ce=0 freezes every register. Optional score bars via `SCORE_BAR_EN.
module scene_renderer #(
    parameter int         H_VIS    = 640,
    parameter int         H_FP     = 16,
    parameter int         H_SYNC   = 96,
    parameter int         H_BP     = 48,
    parameter int         V_VIS    = 480,
    parameter int         V_FP     = 10,
    parameter int         V_SYNC   = 2,
    parameter int         V_BP     = 33,
    parameter int         BALL_R   = 4,
    parameter int         USER_HW  = 60,
    parameter int         USER_HH  = 10,
    parameter int         BLOCK_HW = 60,
    parameter int         BLOCK_HH = 30,
    parameter int         WALL_L   = 16,
    parameter int         WALL_R   = 624,
    parameter logic [7:0] C_BALL   = 8'hFF,
    parameter logic [7:0] C_USER1  = 8'h1F,
    parameter logic [7:0] C_USER2  = 8'hE0,
    parameter logic [7:0] C_BLOCK  = 8'h92,
    parameter logic [7:0] C_WALL   = 8'h49,
    parameter logic [7:0] C_BG     = 8'h00,
    parameter logic [7:0] C_OVER   = 8'hE3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_ce,
    input  logic       disp_sel,
    input  logic [3:0] score_user1,
    input  logic [3:0] score_user2,
    input  logic [9:0] ball_xaddr,
    input  logic [9:0] ball_yaddr,
    input  logic [9:0] user1_xaddr,
    input  logic [9:0] user1_yaddr,
    input  logic [9:0] user2_xaddr,
    input  logic [9:0] user2_yaddr,
    input  logic [9:0] block1_xaddr,
    input  logic [9:0] block1_yaddr,
    input  logic [9:0] block2_xaddr,
    input  logic [9:0] block2_yaddr,
    input  logic [9:0] block3_xaddr,
    input  logic [9:0] block3_yaddr,
    output logic [9:0] xaddr,
    output logic [9:0] yaddr,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [7:0] rgb
);

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } coord_t;

    typedef struct packed {
        logic ball;
        logic user1;
        logic user2;
        logic block;
        logic wall;
`ifdef SCORE_BAR_EN
        logic bar1;
        logic bar2;
`endif
    } hit_t;

    localparam logic [9:0]  H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  V_LOAD   = 10'(V_VIS - 1);
    localparam logic [9:0]  HS_BEG   = 10'(H_VIS + H_FP);
    localparam logic [9:0]  HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0]  VS_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0]  H_VIS10  = 10'(H_VIS);
    localparam logic [9:0]  V_VIS10  = 10'(V_VIS);
    localparam logic [10:0] H_VIS11  = 11'(H_VIS);
    localparam logic [10:0] V_VIS11  = 11'(V_VIS);
    localparam logic [10:0] BALL_R11 = 11'(BALL_R);
    localparam logic [10:0] U_HW11   = 11'(USER_HW);
    localparam logic [10:0] U_HH11   = 11'(USER_HH);
    localparam logic [10:0] B_HW11   = 11'(BLOCK_HW);
    localparam logic [10:0] B_HH11   = 11'(BLOCK_HH);
    localparam logic [10:0] WALL_L11 = 11'(WALL_L);
    localparam logic [10:0] WALL_R11 = 11'(WALL_R);

    logic [9:0] hcnt;
    logic [9:0] vcnt;

    assign xaddr = hcnt;
    assign yaddr = vcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= 10'd0;
            vcnt <= 10'd0;
        end else if (pix_ce) begin
            if (hcnt == H_LAST) begin
                hcnt <= 10'd0;
                vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end
        end
    end

    // Shadows change only after the last visible pixel, so no frame ever mixes old and new positions.
    coord_t     sh_ball, sh_user1, sh_user2, sh_block1, sh_block2, sh_block3;
    logic [3:0] sh_score1, sh_score2;
    logic       sh_over;
    logic       shadow_load;

    assign shadow_load = pix_ce && (hcnt == H_LAST) && (vcnt == V_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_ball   <= {10'd320, 10'd440};
            sh_user1  <= {10'd320, 10'd20};
            sh_user2  <= {10'd320, 10'd460};
            sh_block1 <= {10'd120, 10'd120};
            sh_block2 <= {10'd320, 10'd120};
            sh_block3 <= {10'd520, 10'd120};
            sh_score1 <= 4'd0;
            sh_score2 <= 4'd0;
            sh_over   <= 1'b0;
        end else if (shadow_load) begin
            sh_ball   <= {ball_xaddr, ball_yaddr};
            sh_user1  <= {user1_xaddr, user1_yaddr};
            sh_user2  <= {user2_xaddr, user2_yaddr};
            sh_block1 <= {block1_xaddr, block1_yaddr};
            sh_block2 <= {block2_xaddr, block2_yaddr};
            sh_block3 <= {block3_xaddr, block3_yaddr};
            sh_score1 <= score_user1;
            sh_score2 <= score_user2;
            sh_over   <= disp_sel;
        end
    end

    // 11-bit compare keeps cx-HW from wrapping; centres off the visible area draw nothing.
    function automatic logic in_box(input logic [10:0] px, input logic [10:0] py,
                                    input coord_t c, input logic [10:0] hw, input logic [10:0] hh);
        logic [10:0] cx;
        logic [10:0] cy;
        cx = {1'b0, c.x};
        cy = {1'b0, c.y};
        return (cx < H_VIS11) && (cy < V_VIS11) &&
               (px + hw >= cx) && (px <= cx + hw) &&
               (py + hh >= cy) && (py <= cy + hh);
    endfunction

    logic [10:0] x11;
    logic [10:0] y11;
    hit_t        hit_c;
    logic        hs_c;
    logic        vs_c;
    logic        vis_c;

    assign x11   = {1'b0, hcnt};
    assign y11   = {1'b0, vcnt};
    assign hs_c  = !((hcnt >= HS_BEG) && (hcnt <= HS_END));
    assign vs_c  = !((vcnt >= VS_BEG) && (vcnt <= VS_END));
    assign vis_c = (hcnt < H_VIS10) && (vcnt < V_VIS10);

`ifdef SCORE_BAR_EN
    logic [10:0] bar1_len;
    logic [10:0] bar2_len;
    assign bar1_len = {3'b000, sh_score1, 4'b0000};
    assign bar2_len = {3'b000, sh_score2, 4'b0000};
`endif

    always_comb begin
        hit_c       = '0;
        hit_c.ball  = in_box(x11, y11, sh_ball, BALL_R11, BALL_R11);
        hit_c.user1 = in_box(x11, y11, sh_user1, U_HW11, U_HH11);
        hit_c.user2 = in_box(x11, y11, sh_user2, U_HW11, U_HH11);
        hit_c.block = in_box(x11, y11, sh_block1, B_HW11, B_HH11) ||
                      in_box(x11, y11, sh_block2, B_HW11, B_HH11) ||
                      in_box(x11, y11, sh_block3, B_HW11, B_HH11);
        hit_c.wall  = (x11 < WALL_L11) || (x11 >= WALL_R11);
`ifdef SCORE_BAR_EN
        hit_c.bar1  = (vcnt < 10'd8) && (x11 >= WALL_L11) && (x11 < WALL_L11 + bar1_len);
        hit_c.bar2  = (vcnt < 10'd8) && (x11 <= WALL_R11) && (x11 + bar2_len > WALL_R11);
`endif
    end

    // Stage 1: hit flags plus everything stage 2 needs, so a shadow load cannot skew a pixel.
    logic s1_vld, s1_vid, s1_hs, s1_vs, s1_over, s1_win1, s1_win2;
    hit_t s1_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_vid  <= 1'b0;
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
            s1_over <= 1'b0;
            s1_win1 <= 1'b0;
            s1_win2 <= 1'b0;
            s1_hit  <= '0;
        end else if (pix_ce) begin
            s1_vld  <= 1'b1;
            s1_vid  <= vis_c;
            s1_hs   <= hs_c;
            s1_vs   <= vs_c;
            s1_over <= sh_over;
            s1_win1 <= sh_score1 > sh_score2;
            s1_win2 <= sh_score2 > sh_score1;
            s1_hit  <= hit_c;
        end
    end

    logic [7:0] colour_c;

    always_comb begin
        colour_c = C_BG;
        if (s1_over) begin
            colour_c = C_OVER;
            if (s1_win1 && s1_hit.user1)
                colour_c = C_USER1;
            else if (s1_win2 && s1_hit.user2)
                colour_c = C_USER2;
        end else if (s1_hit.ball) begin
            colour_c = C_BALL;
        end else if (s1_hit.user1) begin
            colour_c = C_USER1;
        end else if (s1_hit.user2) begin
            colour_c = C_USER2;
        end else if (s1_hit.block) begin
            colour_c = C_BLOCK;
        end else if (s1_hit.wall) begin
            colour_c = C_WALL;
        end
`ifdef SCORE_BAR_EN
        if (s1_hit.bar1)
            colour_c = C_USER1;
        else if (s1_hit.bar2)
            colour_c = C_USER2;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
            rgb      <= 8'h00;
        end else if (pix_ce) begin
            hsync    <= s1_hs;
            vsync    <= s1_vs;
            video_on <= s1_vld && s1_vid;
            rgb      <= (s1_vld && s1_vid) ? colour_c : 8'h00;
        end
    end

endmodule

// File: tb/tb_scene_renderer.sv
// Bench for scene_renderer on a reduced raster (144x46 total, 128x40 visible) so several frames fit the run.
// A frame-level model predicts every output each cycle; literal pixel checks pin the model.
module tb_scene_renderer;

    localparam int HV = 128, HFP = 4, HSY = 8, HBP = 4;
    localparam int VV = 40, VFP = 2, VSY = 2, VBP = 2;
    localparam int HT = HV + HFP + HSY + HBP;
    localparam int VT = VV + VFP + VSY + VBP;
    localparam int BR = 4, UHW = 12, UHH = 2, BHW = 10, BHH = 4;
    localparam int WL = 8, WR = 120;
    localparam logic [10:0] RST_E = {1'b1, 1'b1, 1'b0, 8'h00};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_ce;
    logic       disp_sel;
    logic [3:0] score_user1, score_user2;
    logic [9:0] in_x [6];
    logic [9:0] in_y [6];
    logic [9:0] xaddr, yaddr;
    logic       hsync, vsync, video_on;
    logic [7:0] rgb;

    int n_cmp = 0;
    int n_err = 0;
    bit done = 0;

    always #5 clk = ~clk;

    scene_renderer #(
        .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .BALL_R(BR), .USER_HW(UHW), .USER_HH(UHH), .BLOCK_HW(BHW), .BLOCK_HH(BHH),
        .WALL_L(WL), .WALL_R(WR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .disp_sel(disp_sel),
        .score_user1(score_user1), .score_user2(score_user2),
        .ball_xaddr(in_x[0]), .ball_yaddr(in_y[0]),
        .user1_xaddr(in_x[1]), .user1_yaddr(in_y[1]),
        .user2_xaddr(in_x[2]), .user2_yaddr(in_y[2]),
        .block1_xaddr(in_x[3]), .block1_yaddr(in_y[3]),
        .block2_xaddr(in_x[4]), .block2_yaddr(in_y[4]),
        .block3_xaddr(in_x[5]), .block3_yaddr(in_y[5]),
        .xaddr(xaddr), .yaddr(yaddr), .hsync(hsync), .vsync(vsync),
        .video_on(video_on), .rgb(rgb)
    );

    // ---------------- model: what each raster pixel must look like ----------------
    int          m_cx [6];
    int          m_cy [6];
    int          m_s1, m_s2;
    bit          m_over;
    int          m_t;
    logic [10:0] m_e1, m_e2;

    function automatic bit inbox(int x, int y, int i, int hw, int hh);
        int dx, dy;
        dx = (x > m_cx[i]) ? x - m_cx[i] : m_cx[i] - x;
        dy = (y > m_cy[i]) ? y - m_cy[i] : m_cy[i] - y;
        return (m_cx[i] < HV) && (m_cy[i] < VV) && (dx <= hw) && (dy <= hh);
    endfunction

    function automatic logic [10:0] exp_px(int x, int y);
        logic [7:0] c;
        bit hs, vs, vis;
        vis = (x < HV) && (y < VV);
        hs  = !((x >= HV + HFP) && (x < HV + HFP + HSY));
        vs  = !((y >= VV + VFP) && (y < VV + VFP + VSY));
        c   = 8'h00;
        if (vis) begin
            if (m_over) begin
                c = 8'hE3;
                if (m_s1 > m_s2 && inbox(x, y, 1, UHW, UHH)) c = 8'h1F;
                else if (m_s2 > m_s1 && inbox(x, y, 2, UHW, UHH)) c = 8'hE0;
            end else if (inbox(x, y, 0, BR, BR)) c = 8'hFF;
            else if (inbox(x, y, 1, UHW, UHH)) c = 8'h1F;
            else if (inbox(x, y, 2, UHW, UHH)) c = 8'hE0;
            else if (inbox(x, y, 3, BHW, BHH) || inbox(x, y, 4, BHW, BHH) || inbox(x, y, 5, BHW, BHH)) c = 8'h92;
            else if (x < WL || x >= WR) c = 8'h49;
`ifdef SCORE_BAR_EN
            if (y < 8 && x >= WL && x < WL + 16 * m_s1) c = 8'h1F;
            else if (y < 8 && x <= WR && x > WR - 16 * m_s2) c = 8'hE0;
`endif
        end
        return {hs, vs, vis, c};
    endfunction

    task automatic model_reset();
        m_cx = '{320, 320, 320, 120, 320, 520};
        m_cy = '{440, 20, 460, 120, 120, 120};
        m_s1 = 0; m_s2 = 0; m_over = 0; m_t = 0;
        m_e1 = RST_E; m_e2 = RST_E;
    endtask

    initial begin
        int h, v;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else if (pix_ce) begin
                h = m_t % HT;
                v = m_t / HT;
                m_e2 = m_e1;
                m_e1 = exp_px(h, v);
                if (h == HT - 1 && v == VV - 1) begin
                    for (int i = 0; i < 6; i++) begin
                        m_cx[i] = int'(in_x[i]);
                        m_cy[i] = int'(in_y[i]);
                    end
                    m_s1 = int'(score_user1); m_s2 = int'(score_user2); m_over = disp_sel;
                end
                m_t = (m_t + 1) % (HT * VT);
            end
        end
    end

    // ---------------- every-cycle compare ----------------
    initial begin
        logic [30:0] act, exp;
        forever begin
            @(negedge clk);
            if (!done) begin
                act = {xaddr, yaddr, hsync, vsync, video_on, rgb};
                exp = {10'(m_t % HT), 10'(m_t / HT), m_e2};
                n_cmp++;
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL cycle_cmp t=%0t: {x,y,hs,vs,von,rgb} got %h expected %h", $time, act, exp);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_raster(input int h, input int v, output bit ok);
        ok = 0;
        for (int i = 0; i < 2 * HT * VT + 16; i++) begin
            @(negedge clk);
            if (xaddr == 10'(h) && yaddr == 10'(v)) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Pixel (x,y) reaches rgb two ticks after the raster is at (x,y).
    task automatic check_px(input int x, input int y, input logic [7:0] e, input string name);
        bit ok;
        wait_raster(x + 2, y, ok);
        n_cmp++;
        if (!ok || rgb !== e) begin
            n_err++;
            $display("FAIL %s: rgb=%h expected %h at (%0d,%0d) reached=%0d", name, rgb, e, x, y, ok);
        end
    endtask

    task automatic set_obj(input int i, input int x, input int y);
        in_x[i] = 10'(x);
        in_y[i] = 10'(y);
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 6; i++) begin
            in_x[i] = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 140));
            in_y[i] = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 50));
        end
        disp_sel    = ($urandom_range(0, 3) == 0);
        score_user1 = 4'($urandom_range(0, 15));
        score_user2 = 4'($urandom_range(0, 15));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int lo, von;
        rst_n = 1'b0; pix_ce = 1'b0; disp_sel = 1'b0;
        score_user1 = 4'd0; score_user2 = 4'd0;
        set_obj(0, 30, 20);  set_obj(1, 64, 3);  set_obj(2, 64, 37);
        set_obj(3, 5, 25);   set_obj(4, 64, 25); set_obj(5, 125, 25);
        repeat (3) @(negedge clk);
        pix_ce = 1'b1;
        @(negedge clk);
        chk("reset_rgb", int'(rgb), 0);
        chk("reset_hsync", int'(hsync), 1);
        chk("reset_vsync", int'(vsync), 1);
        chk("reset_video_on", int'(video_on), 0);
        chk("reset_xaddr", int'(xaddr), 0);
        rst_n = 1'b1;

        // frame 0 shows reset shadows; wait past its load point
        wait_raster(0, VV + 1, ok);
        chk("reach_frame1", int'(ok), 1);
        check_px(30, 20, 8'hFF, "ball_centre");
        check_px(35, 20, 8'h00, "beside_ball_bg");
        check_px(3, 20, 8'h49, "left_wall");
        check_px(0, 25, 8'h92, "block1_clipped_x0");
        check_px(127, 25, 8'h92, "block3_over_right_wall");

        wait_raster(0, 30, ok);
        set_obj(0, 50, 36);
        check_px(50, 36, 8'h00, "no_tear_same_frame");
        check_px(50, 36, 8'hFF, "moved_ball_next_frame");

        set_obj(0, 64, 3);
        check_px(64, 3, 8'hFF, "ball_over_user1");
        check_px(74, 3, 8'h1F, "user1_beside_ball");

        disp_sel = 1'b1; score_user1 = 4'd5; score_user2 = 4'd3;
        wait_raster(0, 10, ok);
        lo = 0; von = 0;
        repeat (HT) begin
            @(negedge clk);
            lo  += int'(!hsync);
            von += int'(video_on);
        end
        chk("hsync_low_ticks", lo, HSY);
        chk("video_on_ticks_per_line", von, HV);

        check_px(64, 3, 8'h1F, "over_winner_paddle");
        check_px(30, 20, 8'hE3, "over_background");
        score_user1 = 4'd3;
        check_px(64, 3, 8'hE3, "over_tie_no_paddle");
`ifdef SCORE_BAR_EN
        check_px(8, 4, 8'h1F, "bar1_start");
        check_px(56, 4, 8'hE3, "bar1_end_excl");
`endif
        check_px(30, 20, 8'hE3, "over_tie_bg");

        // asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rgb", int'(rgb), 0);
        chk("async_rst_hsync", int'(hsync), 1);
        chk("async_rst_vsync", int'(vsync), 1);
        chk("async_rst_video_on", int'(video_on), 0);
        chk("async_rst_xaddr", int'(xaddr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_xaddr", int'(xaddr), 1);
        chk("restart_yaddr", int'(yaddr), 0);

        // random phase: gated pix_ce and inputs changing at arbitrary times
        repeat (20000) begin
            @(negedge clk);
            pix_ce = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) rand_inputs();
        end

        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
